// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, controller state encoding,
// round-key bank type and the round-constant lookup.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_W      = 128;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] RD_MAX   = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_e;

  typedef logic [KEY_W-1:0] rk_bank_t [0:NUM_ROUNDS];

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/key_gen.sv
// One AES-128 key-expansion step: next round key from the current one and
// the round index (which selects the round constant).
module key_gen
  import aes_pkg::*;
(
  input  logic [3:0]       rnd_i,
  input  logic [KEY_W-1:0] key_i,
  output logic [KEY_W-1:0] key_o
);

  logic [31:0] rot_w, sub_w, tmp_w;
  logic [31:0] n0, n1, n2, n3;

  assign rot_w = {key_i[23:0], key_i[31:24]};

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_sbox
    s_box u_sbox (
      .a_i(rot_w[gi*8 +: 8]),
      .s_o(sub_w[gi*8 +: 8])
    );
  end

  assign tmp_w = sub_w ^ {rcon(rnd_i), 24'h000000};
  assign n0    = key_i[127:96] ^ tmp_w;
  assign n1    = key_i[95:64]  ^ n0;
  assign n2    = key_i[63:32]  ^ n1;
  assign n3    = key_i[31:0]   ^ n2;
  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/s_box.sv
// AES forward S-box, computed as the GF(2^8) multiplicative inverse (x^254)
// followed by the affine transform, so no 256-entry table is needed.
module s_box (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x12, x15, x240, inv;

  // Addition chain to x^254; zero maps to zero as the S-box requires.
  always_comb begin
    x2   = gf_mul(a_i, a_i);
    x3   = gf_mul(x2, a_i);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
  end

  assign s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 key-schedule sequencer: expands key_in into an 11-entry round-key
// bank, one round per cycle, then serves indexed reads with 1-cycle latency.
// Optional zeroize input is enabled by defining KEY_SCHED_ZEROIZE_EN.
module key_sched_ctrl
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic             zeroize,
`endif
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic             key_valid,
  input  logic             rd_en,
  input  logic [3:0]       rd_round,
  output logic [KEY_W-1:0] rk_out,
  output logic             rd_valid
);

  state_e           state_q, state_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [KEY_W-1:0] cur_q, cur_d;
  logic             done_q, done_d;
  logic             load0, wr_exp;
  logic [3:0]       wr_idx;
  logic [KEY_W-1:0] nxt;
  logic             zero_w;
  rk_bank_t         bank_q;
  logic [KEY_W-1:0] rk_out_q;
  logic             rd_valid_q;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign zero_w = zeroize;
`else
  assign zero_w = 1'b0;
`endif

  key_gen u_key_gen (
    .rnd_i(rnd_q),
    .key_i(cur_q),
    .key_o(nxt)
  );

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
    load0   = 1'b0;
    wr_exp  = 1'b0;
    if (zero_w) begin
      state_d = IDLE;
      rnd_d   = 4'd0;
      cur_d   = '0;
    end else begin
      case (state_q)
        IDLE, READY: begin
          if (start) begin
            state_d = EXPAND;
            rnd_d   = 4'd0;
            cur_d   = key_in;
            load0   = 1'b1;
          end
        end
        EXPAND: begin
          cur_d  = nxt;
          wr_exp = 1'b1;
          rnd_d  = rnd_q + 4'd1;
          if (rnd_q == LAST_RND) begin
            state_d = READY;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      cur_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
    end
  end

  assign wr_idx = rnd_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) bank_q[i] <= '0;
    end else if (zero_w) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) bank_q[i] <= '0;
    end else begin
      if (load0)  bank_q[0]      <= key_in;
      if (wr_exp) bank_q[wr_idx] <= nxt;
    end
  end

  // Reads sample the bank before this edge's write, so the final expansion
  // write is never visible to a read issued in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_out_q   <= '0;
      rd_valid_q <= 1'b0;
    end else if (zero_w) begin
      rk_out_q   <= '0;
      rd_valid_q <= 1'b0;
    end else if (rd_en) begin
      if (rd_round > RD_MAX) begin
        rk_out_q   <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rk_out_q   <= bank_q[rd_round];
        rd_valid_q <= (state_q == READY);
      end
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign busy      = (state_q == EXPAND);
  assign key_valid = (state_q == READY);
  assign done      = done_q;
  assign rk_out    = rk_out_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Self-checking bench for key_sched_ctrl: FIPS-197 vectors, read-port corner
// cases, restart/reset/zeroize sequences and randomized keys vs a word-level model.
module tb_key_sched_ctrl;

  logic         clk;
  logic         rst_n;
  logic         zeroize;
  logic         start;
  logic [127:0] key_in;
  logic         busy, done, key_valid;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic [127:0] rk_out;
  logic         rd_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  key_sched_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef KEY_SCHED_ZEROIZE_EN
    .zeroize  (zeroize),
`endif
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .done     (done),
    .key_valid(key_valid),
    .rd_en    (rd_en),
    .rd_round (rd_round),
    .rk_out   (rk_out),
    .rd_valid (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: table S-box from the generator-3 walk, word-wise expansion.
  logic [7:0]   sbox_tbl [256];
  logic [127:0] model_rk [11];

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tbl[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tbl[0] = 8'h63;
  endtask

  task automatic expand_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) model_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 15 && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    check(name, seen, 1'b1);
  endtask

  typedef struct {
    logic         en;
    logic [3:0]   rnd;
    logic [127:0] rk;
    logic         v;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int done_at, done_cnt;
    logic [127:0] exp_rk;
    logic         exp_v;

    vecs[0] = '{1'b1, 4'd1,  FIPS_R1,  1'b1};
    vecs[1] = '{1'b1, 4'd10, FIPS_R10, 1'b1};
    vecs[2] = '{1'b1, 4'd0,  FIPS_KEY, 1'b1};
    vecs[3] = '{1'b1, 4'd11, 128'h0,   1'b0};
    vecs[4] = '{1'b0, 4'd3,  128'h0,   1'b0};
    vecs[5] = '{1'b1, 4'd15, 128'h0,   1'b0};
    vecs[6] = '{1'b1, 4'd2,  FIPS_R2,  1'b1};
    vecs[7] = '{1'b0, 4'd0,  FIPS_R2,  1'b0};

    build_sbox();
    expand_model(FIPS_KEY);

    rst_n = 1'b0; zeroize = 1'b0; start = 1'b0; key_in = '0;
    rd_en = 1'b0; rd_round = 4'd0;
    repeat (3) step();
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_key_valid", key_valid, 1'b0);
    check("reset_rk_out", rk_out, 128'h0);
    check("reset_rd_valid", rd_valid, 1'b0);
    rst_n = 1'b1;
    step();
    rd_en = 1'b1; rd_round = 4'd0;
    step();
    rd_en = 1'b0;
    check("idle_read_valid", rd_valid, 1'b0);
    check("idle_read_rk", rk_out, 128'h0);

    // FIPS expansion with a stray start in the middle; done must stay on time.
    start = 1'b1; key_in = FIPS_KEY;
    step();
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_key_valid", key_valid, 1'b0);
    done_at = 0; done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) begin start = 1'b1; key_in = 128'hdeadbeef_01234567_89abcdef_cafef00d; end
      step();
      start = 1'b0;
      if (done) begin done_cnt++; if (done_at == 0) done_at = k; end
      if (k == 10) check("ready_key_valid", key_valid, 1'b1);
      if (k == 10) check("ready_busy", busy, 1'b0);
    end
    check("done_latency", 128'(done_at), 128'd10);
    check("done_pulse_count", 128'(done_cnt), 128'd1);

    for (int i = 0; i < 8; i++) begin
      rd_en = vecs[i].en; rd_round = vecs[i].rnd;
      step();
      check($sformatf("vec%0d_rk", i), rk_out, vecs[i].rk);
      check($sformatf("vec%0d_valid", i), rd_valid, vecs[i].v);
    end

    for (int r = 10; r >= 0; r--) begin
      rd_en = 1'b1; rd_round = 4'(r);
      step();
      check($sformatf("sweep%0d_rk", r), rk_out, model_rk[r]);
      check($sformatf("sweep%0d_valid", r), rd_valid, 1'b1);
    end
    rd_en = 1'b0;

    // Restart from READY with the all-zero key, reading across the restart.
    start = 1'b1; key_in = '0; rd_en = 1'b1; rd_round = 4'd0;
    step();
    start = 1'b0; rd_en = 1'b0;
    check("restart_read_rk", rk_out, FIPS_KEY);
    check("restart_read_valid", rd_valid, 1'b1);
    check("restart_key_valid", key_valid, 1'b0);
    check("restart_busy", busy, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      rd_en = (k == 5 || k == 10);
      rd_round = (k == 5) ? 4'd1 : 4'd10;
      step();
      if (k == 5) begin
        check("busy_read_rk", rk_out, ZERO_R1);
        check("busy_read_valid", rd_valid, 1'b0);
      end
      if (k == 10) begin
        check("final_write_done", done, 1'b1);
        check("final_write_old_rk", rk_out, FIPS_R10);
        check("final_write_valid", rd_valid, 1'b0);
      end
    end
    rd_en = 1'b1; rd_round = 4'd1;
    step();
    rd_en = 1'b0;
    check("zero_key_r1", rk_out, ZERO_R1);
    check("zero_key_r1_valid", rd_valid, 1'b1);

    // Asynchronous reset in the middle of an expansion.
    start = 1'b1; key_in = FIPS_KEY;
    step();
    start = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_key_valid", key_valid, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_rk_out", rk_out, 128'h0);
    check("midrst_rd_valid", rd_valid, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1; key_in = FIPS_KEY;
    step();
    start = 1'b0; rd_en = 1'b1; rd_round = 4'd3;
    step();
    rd_en = 1'b0;
    check("midrst_bank3_cleared", rk_out, 128'h0);
    check("midrst_bank3_valid", rd_valid, 1'b0);
    wait_done("midrst_done_seen");
    rd_en = 1'b1; rd_round = 4'd3;
    step();
    rd_en = 1'b0;
    check("midrst_bank3_after", rk_out, model_rk[3]);
    check("midrst_bank3_after_valid", rd_valid, 1'b1);

`ifdef KEY_SCHED_ZEROIZE_EN
    zeroize = 1'b1; start = 1'b1; key_in = FIPS_KEY;
    step();
    zeroize = 1'b0; start = 1'b0;
    check("zeroize_busy", busy, 1'b0);
    check("zeroize_key_valid", key_valid, 1'b0);
    step();
    check("zeroize_idle", busy, 1'b0);
    rd_en = 1'b1; rd_round = 4'd10;
    step();
    rd_en = 1'b0;
    check("zeroize_r10", rk_out, 128'h0);
    check("zeroize_r10_valid", rd_valid, 1'b0);
`endif

    // Randomized keys and reads against the model.
    exp_rk = rk_out;
    for (int n = 0; n < 4; n++) begin
      key_in = {$urandom, $urandom, $urandom, $urandom};
      expand_model(key_in);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done($sformatf("rand%0d_done_seen", n));
      for (int j = 0; j < 20; j++) begin
        rd_en = (j == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        rd_round = 4'($urandom_range(0, 15));
        exp_v = 1'b0;
        if (rd_en) begin
          if (rd_round <= 4'd10) begin
            exp_rk = model_rk[rd_round];
            exp_v = 1'b1;
          end else begin
            exp_rk = '0;
          end
        end
        step();
        $display("txn key%0d.%0d rd_en=%0b round=%0d rk_out=%h rd_valid=%0b",
                 n, j, rd_en, rd_round, rk_out, rd_valid);
        check($sformatf("rand%0d_%0d_rk", n, j), rk_out, exp_rk);
        check($sformatf("rand%0d_%0d_valid", n, j), rd_valid, exp_v);
      end
      rd_en = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
